// File: rtl/telem_tx_sched.sv
// Byte scheduler sharing one UART transmitter between single-byte command responses
// and 11-byte checksummed telemetry packets; responses win arbitration in idle.
module telem_tx_sched #(
  parameter logic [7:0] HDR0 = 8'hAA,
  parameter logic [7:0] HDR1 = 8'h55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_telem,
  input  logic [15:0] ptch,
  input  logic [15:0] roll,
  input  logic [15:0] yaw,
  input  logic [15:0] batt,
  input  logic        resp_req,
  input  logic [7:0]  resp_byte,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        pkt_done,
  output logic        ovr
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  typedef enum logic {ModeRsp, ModeTel} mode_e;

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [63:0] snap_q, snap_d;
  logic        tel_pend_q, tel_pend_d;
  logic        rsp_pend_q, rsp_pend_d;
  logic [7:0]  rsp_reg_q, rsp_reg_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        trmt_q, busy_q, pkt_done_q, pkt_done_d, ovr_q, ovr_d;
  logic        tel_clr, rsp_clr;
  logic [3:0]  nxt_idx;
  logic [2:0]  pay_off;
  logic [7:0]  pkt_byte;

  // Byte for the index about to be issued; payload bytes come from the snapshot, MSB first.
  always_comb begin
    nxt_idx = 4'(idx_q + 4'd1);
    pay_off = 3'(4'd9 - nxt_idx);
    unique case (nxt_idx)
      4'd1:    pkt_byte = HDR1;
      4'd10:   pkt_byte = ~sum_q;
      default: pkt_byte = snap_q[{pay_off, 3'b000} +: 8];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    snap_d     = snap_q;
    tx_data_d  = tx_data_q;
    pkt_done_d = 1'b0;
    tel_clr    = 1'b0;
    rsp_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rsp_pend_q) begin
          tx_data_d = rsp_reg_q;
          mode_d    = ModeRsp;
          rsp_clr   = 1'b1;
          state_d   = StIssue;
        end else if (tel_pend_q) begin
          snap_d    = {ptch, roll, yaw, batt};
          sum_d     = 8'h00;
          idx_d     = 4'd0;
          tx_data_d = HDR0;
          mode_d    = ModeTel;
          tel_clr   = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (tx_done) begin
          if (mode_q == ModeRsp) begin
            state_d = StIdle;
          end else if (idx_q != 4'd10) begin
            idx_d     = nxt_idx;
            tx_data_d = pkt_byte;
            if (nxt_idx != 4'd1 && nxt_idx != 4'd10) sum_d = sum_q + pkt_byte;
            state_d   = StIssue;
          end else begin
            pkt_done_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A request landing on the cycle its flag clears becomes a fresh pending request.
    tel_pend_d = (tel_pend_q & ~tel_clr) | send_telem;
    rsp_pend_d = (rsp_pend_q & ~rsp_clr) | resp_req;
    rsp_reg_d  = resp_req ? resp_byte : rsp_reg_q;
    ovr_d      = (send_telem & tel_pend_q & ~tel_clr) | (resp_req & rsp_pend_q & ~rsp_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= ModeRsp;
      idx_q      <= 4'd0;
      sum_q      <= 8'h00;
      snap_q     <= 64'h0;
      tel_pend_q <= 1'b0;
      rsp_pend_q <= 1'b0;
      rsp_reg_q  <= 8'h00;
      tx_data_q  <= 8'h00;
      trmt_q     <= 1'b0;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      snap_q     <= snap_d;
      tel_pend_q <= tel_pend_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_reg_q  <= rsp_reg_d;
      tx_data_q  <= tx_data_d;
      trmt_q     <= (state_d == StIssue);
      busy_q     <= (state_d != StIdle);
      pkt_done_q <= pkt_done_d;
      ovr_q      <= ovr_d;
    end
  end

  assign trmt     = trmt_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_telem_tx_sched.sv
// Directed bench for telem_tx_sched: a vector table of single transactions plus hand-written
// sequences for priority, overrun, snapshot hold and mid-packet reset, against a UART stub.
module tb_telem_tx_sched;

  localparam int ByteTime = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send_telem = 1'b0;
  logic [15:0] ptch = '0, roll = '0, yaw = '0, batt = '0;
  logic        resp_req = 1'b0;
  logic [7:0]  resp_byte = '0;
  logic        tx_done;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        busy, pkt_done, ovr;

  always #5 clk = ~clk;

  telem_tx_sched #(.HDR0(8'hAA), .HDR1(8'h55)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .send_telem (send_telem),
    .ptch       (ptch),
    .roll       (roll),
    .yaw        (yaw),
    .batt       (batt),
    .resp_req   (resp_req),
    .resp_byte  (resp_byte),
    .tx_done    (tx_done),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .ovr        (ovr)
  );

  // UART stub: logs each byte, drops tx_done the cycle after trmt, raises it ByteTime later.
  logic [7:0] log_q[$];
  int         cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b0;
      cnt     <= 0;
    end else if (trmt) begin
      tx_done <= 1'b0;
      cnt     <= ByteTime;
      log_q.push_back(tx_data);
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) tx_done <= 1'b1;
    end
  end

  int n_trmt = 0, n_pkt = 0, n_ovr = 0;
  always @(posedge clk) begin
    if (trmt)     n_trmt <= n_trmt + 1;
    if (pkt_done) n_pkt  <= n_pkt + 1;
    if (ovr)      n_ovr  <= n_ovr + 1;
  end

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (log_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (log_q.size() < n) timeout("wait_log");
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int k = 0;
    while (quiet < 4 && k < 5000) begin
      @(negedge clk);
      k++;
      quiet = busy ? 0 : quiet + 1;
    end
    if (quiet < 4) timeout("wait_idle");
  endtask

  function automatic logic [7:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 8'hxx;
  endfunction

  task automatic check_pkt(input string tag, input int at, input logic [15:0] p, r, y, b,
                           input logic [7:0] c);
    logic [7:0] e[11];
    e = '{8'hAA, 8'h55, p[15:8], p[7:0], r[15:8], r[7:0], y[15:8], y[7:0], b[15:8], b[7:0], c};
    for (int k = 0; k < 11; k++) chk($sformatf("%s byte%0d", tag, k), 32'(log_at(at + k)), 32'(e[k]));
  endtask

  // Called at a negedge; the pulse spans exactly one rising edge.
  task automatic pulse(input logic tel, input logic rsp, input logic [7:0] rb);
    send_telem = tel;
    resp_req   = rsp;
    resp_byte  = rb;
    @(negedge clk);
    send_telem = 1'b0;
    resp_req   = 1'b0;
  endtask

  typedef struct {
    bit          tel;
    logic [7:0]  rb;
    logic [15:0] p, r, y, b;
    logic [7:0]  chk;
  } vec_t;

  vec_t vecs[6];
  int   base, p0, o0, t0;

  initial begin
    // Checksums: ~(sum of the eight payload bytes) mod 256.
    vecs[0] = '{0, 8'h3C, 16'h0, 16'h0, 16'h0, 16'h0, 8'h00};
    vecs[1] = '{1, 8'h00, 16'h1234, 16'hFFFE, 16'h0001, 16'h0A0B, 8'hA6};  // sum 59
    vecs[2] = '{1, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'hFF};  // sum 00
    vecs[3] = '{1, 8'h00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h07};  // sum F8
    vecs[4] = '{0, 8'hA5, 16'h0, 16'h0, 16'h0, 16'h0, 8'h00};
    vecs[5] = '{1, 8'h00, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 8'hDB};  // sum 24

    repeat (3) @(negedge clk);
    chk("rst trmt", 32'(trmt), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'h00);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst pkt_done", 32'(pkt_done), 32'd0);
    chk("rst ovr", 32'(ovr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      base = log_q.size();
      p0   = n_pkt;
      o0   = n_ovr;
      ptch = vecs[i].p; roll = vecs[i].r; yaw = vecs[i].y; batt = vecs[i].b;
      pulse(vecs[i].tel, !vecs[i].tel, vecs[i].rb);
      chk($sformatf("v%0d trmt early", i), 32'(trmt), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d trmt at 2", i), 32'(trmt), 32'd1);
      chk($sformatf("v%0d first byte", i), 32'(tx_data), vecs[i].tel ? 32'hAA : 32'(vecs[i].rb));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d trmt one cycle", i), 32'(trmt), 32'd0);
      wait_idle();
      chk($sformatf("v%0d nbytes", i), 32'(log_q.size() - base), vecs[i].tel ? 32'd11 : 32'd1);
      if (vecs[i].tel)
        check_pkt($sformatf("v%0d", i), base, vecs[i].p, vecs[i].r, vecs[i].y, vecs[i].b,
                  vecs[i].chk);
      else
        chk($sformatf("v%0d resp", i), 32'(log_at(base)), 32'(vecs[i].rb));
      chk($sformatf("v%0d pkt_done", i), 32'(n_pkt - p0), vecs[i].tel ? 32'd1 : 32'd0);
      chk($sformatf("v%0d ovr", i), 32'(n_ovr - o0), 32'd0);
    end

    // Response mid-packet waits for the checksum; payload ignores a late ptch change.
    base = log_q.size(); p0 = n_pkt;
    ptch = 16'h1234; roll = 16'hFFFE; yaw = 16'h0001; batt = 16'h0A0B;
    pulse(1'b1, 1'b0, 8'h00);
    wait_log(base + 2);
    ptch = 16'hBEEF;
    wait_log(base + 5);
    pulse(1'b0, 1'b1, 8'h77);
    wait_idle();
    ptch = 16'h1234;
    chk("prio nbytes", 32'(log_q.size() - base), 32'd12);
    check_pkt("snap", base, 16'h1234, 16'hFFFE, 16'h0001, 16'h0A0B, 8'hA6);
    chk("prio resp last", 32'(log_at(base + 11)), 32'h77);
    chk("prio pkt_done", 32'(n_pkt - p0), 32'd1);

    // Simultaneous requests in idle: response goes first.
    base = log_q.size();
    ptch = 16'h0102; roll = 16'h0304; yaw = 16'h0506; batt = 16'h0708;
    pulse(1'b1, 1'b1, 8'hC3);
    wait_idle();
    chk("same nbytes", 32'(log_q.size() - base), 32'd12);
    chk("same resp first", 32'(log_at(base)), 32'hC3);
    check_pkt("same", base + 1, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 8'hDB);

    // Two send_telem during a packet: one queued, one dropped.
    base = log_q.size(); p0 = n_pkt; o0 = n_ovr;
    pulse(1'b1, 1'b0, 8'h00);
    wait_log(base + 3);
    pulse(1'b1, 1'b0, 8'h00);
    pulse(1'b1, 1'b0, 8'h00);
    wait_idle();
    chk("tel ovr", 32'(n_ovr - o0), 32'd1);
    chk("tel ovr nbytes", 32'(log_q.size() - base), 32'd22);
    chk("tel ovr pkts", 32'(n_pkt - p0), 32'd2);

    // Two responses while pending: the second byte wins.
    base = log_q.size(); o0 = n_ovr;
    pulse(1'b1, 1'b0, 8'h00);
    wait_log(base + 3);
    pulse(1'b0, 1'b1, 8'h11);
    pulse(1'b0, 1'b1, 8'h22);
    wait_idle();
    chk("rsp ovr", 32'(n_ovr - o0), 32'd1);
    chk("rsp ovr nbytes", 32'(log_q.size() - base), 32'd12);
    chk("rsp ovr byte", 32'(log_at(base + 11)), 32'h22);

    // Reset at idx 6: outputs clear at once, nothing resumes.
    base = log_q.size();
    pulse(1'b1, 1'b0, 8'h00);
    wait_log(base + 7);
    rst_n = 1'b0;
    #1;
    chk("mid rst trmt", 32'(trmt), 32'd0);
    chk("mid rst tx_data", 32'(tx_data), 32'h00);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst pkt_done", 32'(pkt_done), 32'd0);
    chk("mid rst ovr", 32'(ovr), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t0 = n_trmt;
    repeat (100) @(negedge clk);
    chk("post rst no trmt", 32'(n_trmt - t0), 32'd0);
    chk("post rst busy", 32'(busy), 32'd0);
    base = log_q.size();
    pulse(1'b0, 1'b1, 8'h5A);
    wait_idle();
    chk("post rst nbytes", 32'(log_q.size() - base), 32'd1);
    chk("post rst resp", 32'(log_at(base)), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
